toom3_gf2_scheduler: RTL
========================

TOOM3_GF2_SCHEDULER -- requirements
Module: toom3_gf2_scheduler

Interface
REQ-001: The block SHALL have parameter N, default 384, giving the operand width in bits; N SHALL be a multiple of 3.
REQ-002: The block SHALL derive local constant W = N/3, the limb width (128 at default).
REQ-003: Port clk, input, 1 bit: single clock; all state SHALL change on its rising edge only.
REQ-004: Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005: Port start, input, 1 bit: request to begin a multiplication.
REQ-006: Port abort, input, 1 bit: synchronous cancel of an operation in progress.
REQ-007: Port a, input, N bits: operand A, a GF(2) polynomial with bit k as the coefficient of x^k.
REQ-008: Port b, input, N bits: operand B, same encoding as A.
REQ-009: Port busy, output, 1 bit: high while an operation is in progress.
REQ-010: Port done, output, 1 bit: one-cycle pulse when c holds a completed result.
REQ-011: Port prod_idx, output, 4 bits: index 0..8 of the partial product currently scheduled.
REQ-012: Port c, output, 2N bits: carry-less product A*B over GF(2), registered.

Function
REQ-013: The block SHALL split the operands into limbs a0=a[W-1:0], a1=a[2W-1:W], a2=a[3W-1:2W], and b0, b1, b2 likewise.
REQ-014: The block SHALL time-share one bit-serial W x W carry-less multiplier over nine partial products, in this order (idx: pair, shift): 0: a0b0, 0; 1: a0b1, W; 2: a1b0, W; 3: a0b2, 2W; 4: a1b1, 2W; 5: a2b0, 2W; 6: a1b2, 3W; 7: a2b1, 3W; 8: a2b2, 4W.
REQ-015: FSM states SHALL be IDLE, MUL, ACC and DONE.
REQ-016: IDLE -> MUL when start=1. On that edge the block SHALL latch a and b, clear c to 0, set idx=0, clear the bit counter k and clear the 2W-bit partial register p.
REQ-017: In MUL, each cycle: if a_limb[k]=1 then p <= p XOR (b_limb << k); then k <= k+1. After the cycle with k=W-1, the FSM SHALL go to ACC.
REQ-018: In ACC, c <= c XOR (p << shift[idx]), clearing p and k; if idx<8 then idx <= idx+1 and the FSM goes to MUL, else the FSM goes to DONE.
REQ-019: In DONE, done=1 for exactly one cycle, then the FSM goes to IDLE; c SHALL hold its value until the next accepted start.
REQ-020: Latency: done SHALL be high in the cycle beginning 9*(W+1)+1 rising edges after the edge that samples start (1162 at default).
REQ-021: busy SHALL be 1 in MUL and ACC and 0 in IDLE and DONE; prod_idx SHALL show idx in MUL and ACC and 0 otherwise.
REQ-022: start while busy=1 or in DONE SHALL be ignored, and a and b changes during an operation SHALL have no effect.
REQ-023: abort=1 in MUL or ACC SHALL return the FSM to IDLE on the next edge with no done pulse and c cleared to 0; abort has priority over start, and abort in IDLE or DONE SHALL have no effect.
REQ-024: All XOR arithmetic SHALL be carry-free; p SHALL be 2W-1 bits minimum, and bits shifted beyond 2N-1 SHALL NOT exist (the maximum product degree is 2N-2).

Reset
REQ-025: While rst=0, the block SHALL asynchronously force the FSM to IDLE, c=0, busy=0, done=0, prod_idx=0, and p, k, idx and the latched operands to 0.
REQ-026: Reset asserted mid-operation SHALL discard the operation; after release the block SHALL accept start on the first edge.

Verification
REQ-027: Directed test: a=1, b=1, start pulse -> done after 1162 edges, c=1, busy high for exactly 1161 cycles.
REQ-028: Directed test: a=3, b=3 -> c=5 (carry-less); a=2^383, b=2^383 -> c=2^766.
REQ-029: Directed test: a=b=all-ones (384 bits) -> c has every even bit 0..766 set and every odd bit clear; prod_idx steps 0..8 with each value held 129 cycles.
REQ-030: Directed test: start re-asserted at cycles 5 and 600 of an operation -> ignored; result and latency unchanged.
REQ-031: Directed test: abort at idx=4 -> IDLE next edge, c=0, no done; a subsequent start completes correctly.
REQ-032: Directed test: rst low at idx=7 -> outputs zero immediately; after release, a=random, b=random matches the software carry-less reference model.

Source files
------------

// File: rtl/toom3_gf2_scheduler.sv
// rtl/toom3_gf2_scheduler.sv - three-limb GF(2) multiplier scheduler
// Nine limb products share one bit-serial W x W carry-less multiplier and accumulate into c.
module toom3_gf2_scheduler #(
  parameter int N = 384
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [3:0]     prod_idx,
  output logic [2*N-1:0] c
);
  localparam int W  = N / 3;
  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

  state_t         state_q;
  logic [N-1:0]   a_q, b_q;
  logic [2*W-1:0] p_q, p_d;
  logic [2*N-1:0] c_q, c_d;
  logic [KW-1:0]  k_q;
  logic [3:0]     idx_q;
  logic           busy_q, done_q;

  logic [W-1:0]   a_limb, b_limb;
  logic [2*W-1:0] b_ext;
  logic [2*N-1:0] p_ext;

  // Limb pairing for each partial-product index.
  always_comb begin
    a_limb = a_q[W-1:0];
    b_limb = b_q[W-1:0];
    case (idx_q)
      4'd0: begin a_limb = a_q[W-1:0];     b_limb = b_q[W-1:0];     end
      4'd1: begin a_limb = a_q[W-1:0];     b_limb = b_q[2*W-1:W];   end
      4'd2: begin a_limb = a_q[2*W-1:W];   b_limb = b_q[W-1:0];     end
      4'd3: begin a_limb = a_q[W-1:0];     b_limb = b_q[3*W-1:2*W]; end
      4'd4: begin a_limb = a_q[2*W-1:W];   b_limb = b_q[2*W-1:W];   end
      4'd5: begin a_limb = a_q[3*W-1:2*W]; b_limb = b_q[W-1:0];     end
      4'd6: begin a_limb = a_q[2*W-1:W];   b_limb = b_q[3*W-1:2*W]; end
      4'd7: begin a_limb = a_q[3*W-1:2*W]; b_limb = b_q[2*W-1:W];   end
      default: begin a_limb = a_q[3*W-1:2*W]; b_limb = b_q[3*W-1:2*W]; end
    endcase
  end

  always_comb begin
    b_ext = {{W{1'b0}}, b_limb};
    p_d   = a_limb[k_q] ? (p_q ^ (b_ext << k_q)) : p_q;
    p_ext = {{(2*N-2*W){1'b0}}, p_q};
    case (idx_q)
      4'd0:             c_d = c_q ^ p_ext;
      4'd1, 4'd2:       c_d = c_q ^ (p_ext << W);
      4'd3, 4'd4, 4'd5: c_d = c_q ^ (p_ext << (2*W));
      4'd6, 4'd7:       c_d = c_q ^ (p_ext << (3*W));
      default:          c_d = c_q ^ (p_ext << (4*W));
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q == MUL || state_q == ACC)) begin
        state_q <= IDLE;
        c_q     <= '0;
        p_q     <= '0;
        k_q     <= '0;
        idx_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              a_q     <= a;
              b_q     <= b;
              c_q     <= '0;
              p_q     <= '0;
              k_q     <= '0;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= MUL;
            end
          end
          MUL: begin
            p_q <= p_d;
            k_q <= k_q + KW'(1);
            if (k_q == K_LAST) state_q <= ACC;
          end
          ACC: begin
            c_q <= c_d;
            p_q <= '0;
            k_q <= '0;
            if (idx_q != 4'd8) begin
              idx_q   <= idx_q + 4'd1;
              state_q <= MUL;
            end else begin
              idx_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign prod_idx = idx_q;
  assign c        = c_q;

endmodule
